mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe.sv | 165 ++++++++++++++++
 tb/tb_mux_n_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_pipe
//
// Purpose:
//   Registered N-way multiplexer behind a valid/ready handshake. Each accepted
//   beat carries the input slice chosen by sel, or all-zero data plus an error
//   flag when sel is out of range. The beat is held in a two-entry buffer: an
//   output register (OR) that drives out_* and a skid register (SR) that takes
//   the beat arriving in the cycle OR stalls. Because of the skid register,
//   in_ready comes straight from a flop and has no path from out_ready.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   in_data    in   NUM_IN*WIDTH   packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        in   SEL_W          input index, sampled with the beat
//   in_valid   in   1              upstream beat present
//   in_ready   out  1              block can accept a beat this cycle
//   out_data   out  WIDTH          selected data (registered)
//   out_err    out  1              output beat had an out-of-range sel
//   out_valid  out  1              out_data/out_err hold a beat
//   out_ready  in   1              downstream accepts the beat
//   err_clr    in   1              clears err_sticky
//   err_sticky out  1              set by any accepted out-of-range beat
// -----------------------------------------------------------------------------
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    err_sticky
);

  // Parameter legality is checked while elaborating.
  if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_num_in_check
    $error("mux_n_pipe: NUM_IN must lie in 2..16");
  end
  if ((1 << SEL_W) < NUM_IN) begin : g_sel_w_check
    $error("mux_n_pipe: SEL_W too narrow to address NUM_IN inputs");
  end

  // Output register (OR) and skid register (SR).
  logic             or_valid_q, or_valid_d;
  logic [WIDTH-1:0] or_data_q,  or_data_d;
  logic             or_err_q,   or_err_d;
  logic             sr_valid_q, sr_valid_d;
  logic [WIDTH-1:0] sr_data_q,  sr_data_d;
  logic             sr_err_q,   sr_err_d;
  logic             sticky_q,   sticky_d;

  logic [WIDTH-1:0] beat_data_s;
  logic             beat_err_s;
  logic             accept_s;
  logic             or_free_s;

  // Beat value: selected slice, or zero data with error when sel >= NUM_IN.
  always_comb begin
    beat_data_s = '0;
    beat_err_s  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        beat_data_s = in_data[k*WIDTH +: WIDTH];
        beat_err_s  = 1'b0;
      end else begin
        beat_data_s = beat_data_s;
        beat_err_s  = beat_err_s;
      end
    end
  end

  // Handshake terms; in_ready depends only on the SR flop.
  always_comb begin
    in_ready  = ~sr_valid_q;
    accept_s  = in_valid & ~sr_valid_q;
    // OR can take a new value when it is empty or emptying this edge.
    or_free_s = ~or_valid_q | out_ready;
  end

  // Next-state for the two buffer entries and the sticky error flag.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_err_d   = or_err_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    sr_err_d   = sr_err_q;
    sticky_d   = sticky_q;

    if (or_free_s) begin
      if (sr_valid_q) begin
        // SR drains into OR; input is blocked because in_ready is low.
        or_valid_d = 1'b1;
        or_data_d  = sr_data_q;
        or_err_d   = sr_err_q;
        sr_valid_d = 1'b0;
      end else if (accept_s) begin
        or_valid_d = 1'b1;
        or_data_d  = beat_data_s;
        or_err_d   = beat_err_s;
      end else begin
        // Data is left as-is so out_data does not toggle while idle.
        or_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        // OR stalled with a beat: new beat parks in SR.
        sr_valid_d = 1'b1;
        sr_data_d  = beat_data_s;
        sr_err_d   = beat_err_s;
      end else begin
        sr_valid_d = sr_valid_q;
      end
    end

    // Setting the flag has priority over a simultaneous clear.
    if (accept_s && beat_err_s) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers; reset empties both entries and drops any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_err_q   <= 1'b0;
      sr_valid_q <= 1'b0;
      sr_data_q  <= '0;
      sr_err_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_err_q   <= or_err_d;
      sr_valid_q <= sr_valid_d;
      sr_data_q  <= sr_data_d;
      sr_err_q   <= sr_err_d;
      sticky_q   <= sticky_d;
    end
  end

  // Outputs are driven directly from registers.
  always_comb begin
    out_valid  = or_valid_q;
    out_data   = or_data_q;
    out_err    = or_err_q;
    err_sticky = sticky_q;
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_n_pipe
//
// Self-checking bench for mux_n_pipe (WIDTH=32, NUM_IN=3, SEL_W=2). A queue
// model of the two-entry buffer (in order, capacity two) predicts the outputs
// every cycle; directed sequences add literal expectations, then a long random
// run exercises the handshake.
// -----------------------------------------------------------------------------
module tb_mux_n_pipe;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*W-1:0]  in_data = '0;
  logic [SW-1:0]   sel = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            err_sticky;

  int n_vec = 0;
  int n_err = 0;

  // Model state: beats held by the block in acceptance order, {err, data}.
  logic [W:0] mq[$];
  logic       m_sticky = 1'b0;

  mux_n_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  function automatic void chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk32(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected beat from the selection rule: {err, data}.
  function automatic logic [W:0] exp_beat(logic [N*W-1:0] d, logic [SW-1:0] s);
    int idx;
    idx = int'(s);
    if (idx < N) return {1'b0, d[idx*W +: W]};
    else return {1'b1, {W{1'b0}}};
  endfunction

  // Model update: pop on a transfer, push on an acceptance (room < 2).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_sticky = 1'b0;
      end else begin
        logic       pop_now;
        logic       push_now;
        logic [W:0] b;
        pop_now  = (mq.size() > 0) && out_ready;
        push_now = in_valid && (mq.size() < 2);
        b = exp_beat(in_data, sel);
        if (pop_now) void'(mq.pop_front());
        if (push_now) mq.push_back(b);
        if (push_now && b[W]) m_sticky = 1'b1;
        else if (err_clr) m_sticky = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_err", out_err, 1'b0);
        chk32("rst_out_data", out_data, 32'h0);
        chk1("rst_err_sticky", err_sticky, 1'b0);
      end else begin
        chk1("m_out_valid", out_valid, mq.size() > 0);
        chk1("m_in_ready", in_ready, mq.size() < 2);
        chk1("m_err_sticky", err_sticky, m_sticky);
        if (mq.size() > 0) begin
          chk32("m_out_data", out_data, mq[0][W-1:0]);
          chk1("m_out_err", out_err, mq[0][W]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state with literal expectations.
    step();
    step();
    chk1("reset_valid", out_valid, 1'b0);
    chk1("reset_ready", in_ready, 1'b1);
    chk32("reset_data", out_data, 32'h0);
    chk1("reset_sticky", err_sticky, 1'b0);
    rst_n = 1'b1;

    // Three inputs selected back to back at full rate.
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 2'd0; step();
    chk32("seq_a", out_data, 32'h11111111);
    chk1("seq_a_rdy", in_ready, 1'b1);
    sel = 2'd1; step();
    chk32("seq_b", out_data, 32'h22222222);
    chk1("seq_b_rdy", in_ready, 1'b1);
    sel = 2'd2; step();
    chk32("seq_c", out_data, 32'h33333333);
    chk1("seq_c_err", out_err, 1'b0);
    chk1("seq_c_rdy", in_ready, 1'b1);
    in_valid = 1'b0; step();
    chk1("seq_idle", out_valid, 1'b0);

    // Out-of-range select, then clear the sticky flag.
    in_valid = 1'b1; sel = 2'd3; step();
    chk32("oor_data", out_data, 32'h0);
    chk1("oor_err", out_err, 1'b1);
    chk1("oor_sticky", err_sticky, 1'b1);
    in_valid = 1'b0; err_clr = 1'b1; step();
    chk1("clr_sticky", err_sticky, 1'b0);
    err_clr = 1'b0;

    // Stall: B1 in OR, B2 in SR, B3 held off; then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data[31:0] = 32'hB1B1B1B1; step();
    in_data[31:0] = 32'hB2B2B2B2; step();
    chk1("stall_rdy0", in_ready, 1'b0);
    in_data[31:0] = 32'hB3B3B3B3; step();
    chk1("stall_rdy1", in_ready, 1'b0);
    chk32("stall_b1", out_data, 32'hB1B1B1B1);
    out_ready = 1'b1; step();
    chk32("drain_b2", out_data, 32'hB2B2B2B2);
    chk1("drain_rdy", in_ready, 1'b1);
    step();
    chk32("drain_b3", out_data, 32'hB3B3B3B3);
    chk1("drain_b3_v", out_valid, 1'b1);
    in_valid = 1'b0; step();
    chk1("drain_idle", out_valid, 1'b0);

    // Error acceptance and clear on the same edge: set wins.
    in_valid = 1'b1; sel = 2'd3; err_clr = 1'b1; step();
    chk1("set_wins", err_sticky, 1'b1);
    in_valid = 1'b0; step();
    chk1("clr_after", err_sticky, 1'b0);
    err_clr = 1'b0;

    // Asynchronous reset with both entries full; no stale beat afterwards.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    in_data[63:32] = 32'h5A5A5A5A; step(); step();
    chk1("full_rdy", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk1("async_valid", out_valid, 1'b0);
    chk1("async_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    in_data[95:64] = 32'hABCD0123; step();
    chk1("first_edge_v", out_valid, 1'b1);
    chk32("first_edge_d", out_data, 32'hABCD0123);
    in_valid = 1'b0; step();
    chk1("no_stale0", out_valid, 1'b0);
    step();
    chk1("no_stale1", out_valid, 1'b0);

    // Random traffic at roughly 50% valid/ready.
    for (int i = 0; i < 24000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom};
      err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
